gpmc_reg_bank: RTL and testbench



---
 rtl/gpmc_reg_bank_pkg.sv | 20 ++
 rtl/gpmc_reg_bank_btn_debounce.sv | 49 ++++
 rtl/gpmc_reg_bank.sv | 131 +++++++++++++
 tb/tb_gpmc_reg_bank.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/gpmc_reg_bank_pkg.sv
// Shared register map and access-FSM encodings for the BeagleWire GPMC register bank.
// Software address headers are generated from these values.
package gpmc_reg_bank_pkg;

  localparam int unsigned REG_CTRL    = 0;
  localparam int unsigned REG_STATUS  = 1;
  localparam int unsigned REG_EVENT   = 2;
  localparam int unsigned REG_SCRATCH = 3;
  localparam int unsigned REG_ID      = 4;
  localparam int unsigned REG_WRCNT   = 5;
  localparam int unsigned RAM_BASE    = 8;

  typedef enum logic [1:0] {
    ST_ARMED = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WRITE = 2'd2,
    ST_READ  = 2'd3
  } acc_state_e;

endpackage

// File: rtl/gpmc_reg_bank_btn_debounce.sv
// Per-button debouncer: 2-FF synchronizer, then a level is accepted after it has
// been stable for DEBOUNCE_CYCLES clocks. rise pulses in the cycle a 0->1 is accepted.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);
  import gpmc_reg_bank_pkg::*;

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;

  assign accept = (sync2_q != level_q) && (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      // Any return to the accepted level restarts the stability window.
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (accept) begin
        level_q <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign level = level_q;
  assign rise  = accept & sync2_q;

endmodule

// File: rtl/gpmc_reg_bank.sv
// Register bank behind gpmc_sync: one commit per host access, LED/button/scratch/ID/
// write-counter registers plus general RAM, registered read data on data_in.
module gpmc_reg_bank #(
  parameter int                    ADDR_WIDTH      = 5,
  parameter int                    DATA_WIDTH      = 16,
  parameter int                    DEBOUNCE_CYCLES = 50000,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE        = 16'hBE01
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cs,
  input  logic                  we,
  input  logic                  oe,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic [DATA_WIDTH-1:0] data_in,
  input  logic [1:0]            btn,
  output logic [3:0]            led
);
  import gpmc_reg_bank_pkg::*;

  localparam int RAM_WORDS = (2 ** ADDR_WIDTH) - RAM_BASE;

  // Strobes are active-low levels held for the whole access; the FSM turns each
  // held strobe into a single event and needs cs high before a new access starts.
  logic wr_stb, rd_stb, commit;
  assign wr_stb = !cs && !we && oe;
  assign rd_stb = !cs && we && !oe;

  acc_state_e            state_q;
  logic [DATA_WIDTH-1:0] data_in_q;
  logic [3:0]            ctrl_q, led_q;
  logic [DATA_WIDTH-1:0] scratch_q, wrcnt_q;
  logic [1:0]            event_q, event_d, w1c_mask;
  logic [1:0]            status, rise;
  logic [DATA_WIDTH-1:0] rdata;
  logic [DATA_WIDTH-1:0] ram_q [RAM_WORDS];
  logic [ADDR_WIDTH-1:0] ram_idx;
  logic                  is_ram;

  assign commit  = (state_q == ST_IDLE) && wr_stb;
  assign is_ram  = address >= ADDR_WIDTH'(RAM_BASE);
  assign ram_idx = address - ADDR_WIDTH'(RAM_BASE);

  for (genvar b = 0; b < 2; b++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk   (clk),
      .rst   (rst),
      .din   (btn[b]),
      .level (status[b]),
      .rise  (rise[b])
    );
  end

  // A new press in the same cycle as its W1C clear leaves the bit set.
  always_comb begin
    w1c_mask = '0;
    if (commit && address == ADDR_WIDTH'(REG_EVENT)) w1c_mask = data_out[1:0];
    event_d = (event_q & ~w1c_mask) | rise;
  end

  always_comb begin
    rdata = '0;
    if (is_ram) begin
      rdata = ram_q[ram_idx];
    end else begin
      case (address)
        ADDR_WIDTH'(REG_CTRL):    rdata = {{(DATA_WIDTH-4){1'b0}}, ctrl_q};
        ADDR_WIDTH'(REG_STATUS):  rdata = {{(DATA_WIDTH-2){1'b0}}, status};
        ADDR_WIDTH'(REG_EVENT):   rdata = {{(DATA_WIDTH-2){1'b0}}, event_q};
        ADDR_WIDTH'(REG_SCRATCH): rdata = scratch_q;
        ADDR_WIDTH'(REG_ID):      rdata = ID_VALUE;
        ADDR_WIDTH'(REG_WRCNT):   rdata = wrcnt_q;
        default:                  rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_ARMED;
      data_in_q <= '0;
    end else begin
      case (state_q)
        ST_ARMED: if (cs) state_q <= ST_IDLE;
        ST_IDLE: begin
          if (wr_stb) begin
            state_q <= ST_WRITE;
          end else if (rd_stb) begin
            state_q   <= ST_READ;
            data_in_q <= rdata;
          end
        end
        ST_WRITE: if (!wr_stb) state_q <= ST_IDLE;
        ST_READ: begin
          if (!rd_stb) begin
            state_q   <= ST_IDLE;
            data_in_q <= '0;
          end
        end
        default: state_q <= ST_ARMED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q    <= '0;
      led_q     <= '0;
      scratch_q <= '0;
      wrcnt_q   <= '0;
      event_q   <= '0;
    end else begin
      led_q   <= ctrl_q;
      event_q <= event_d;
      if (commit) begin
        wrcnt_q <= wrcnt_q + 1'b1;
        if (address == ADDR_WIDTH'(REG_CTRL))    ctrl_q    <= data_out[3:0];
        if (address == ADDR_WIDTH'(REG_SCRATCH)) scratch_q <= data_out;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (commit && is_ram) ram_q[ram_idx] <= data_out;
  end

  assign data_in = data_in_q;
  assign led     = led_q;

endmodule

// File: tb/tb_gpmc_reg_bank.sv
// Directed bench for gpmc_reg_bank: bus accesses driven on the falling edge,
// outputs checked on the falling edge against hand-computed values.
module tb_gpmc_reg_bank;

  logic        clk;
  logic        rst;
  logic        cs, we, oe;
  logic [4:0]  address;
  logic [15:0] data_out;
  logic [15:0] data_in;
  logic [1:0]  btn;
  logic [3:0]  led;

  int n_cmp = 0;
  int n_bad = 0;

  gpmc_reg_bank #(
    .ADDR_WIDTH      (5),
    .DATA_WIDTH      (16),
    .DEBOUNCE_CYCLES (8),
    .ID_VALUE        (16'hBE01)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cs       (cs),
    .we       (we),
    .oe       (oe),
    .address  (address),
    .data_out (data_out),
    .data_in  (data_in),
    .btn      (btn),
    .led      (led)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic bus_idle();
    cs = 1'b1; we = 1'b1; oe = 1'b1;
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [15:0] d, input int hold);
    cs = 1'b0; we = 1'b0; oe = 1'b1; address = a; data_out = d;
    cyc(hold);
    bus_idle();
    cyc(1);
  endtask

  task automatic bus_read(input logic [4:0] a, input logic [15:0] exp, input string tag);
    cs = 1'b0; we = 1'b1; oe = 1'b0; address = a;
    cyc(1);
    check({tag, "/first"}, data_in, exp);
    cyc(1);
    check({tag, "/hold"}, data_in, exp);
    bus_idle();
    cyc(1);
    check({tag, "/after"}, data_in, 16'h0000);
  endtask

  initial begin
    rst = 1'b1; btn = 2'b00; address = '0; data_out = '0;
    bus_idle();
    cyc(3);
    rst = 1'b0;
    check("reset_data_in", data_in, 16'h0000);
    check("reset_led", {12'h000, led}, 16'h0000);
    cyc(1);
    bus_read(5'h00, 16'h0000, "reset_ctrl");
    bus_read(5'h01, 16'h0000, "reset_status");
    bus_read(5'h02, 16'h0000, "reset_event");
    bus_read(5'h03, 16'h0000, "reset_scratch");

    // Reset pulse while a write strobe is held: nothing commits until cs goes high
    rst = 1'b1;
    cs = 1'b0; we = 1'b0; oe = 1'b1; address = 5'h00; data_out = 16'h000F;
    cyc(1);
    rst = 1'b0;
    cyc(4);
    check("midrst_led", {12'h000, led}, 16'h0000);
    bus_idle();
    cyc(1);
    bus_read(5'h05, 16'h0000, "midrst_wrcnt");
    bus_write(5'h00, 16'h000F, 1);
    check("ctrl_led", {12'h000, led}, 16'h000F);
    bus_read(5'h05, 16'h0001, "wrcnt_1");

    // Long strobe commits once; write to RO WRCNT is counted but ignored
    bus_write(5'h05, 16'h1234, 10);
    bus_read(5'h05, 16'h0002, "wrcnt_single");
    bus_read(5'h04, 16'hBE01, "id");

    // SCRATCH, RAM, reserved, CTRL upper bits
    bus_write(5'h03, 16'hA5A5, 1);
    bus_write(5'h1F, 16'h5A5A, 1);
    bus_write(5'h08, 16'h1111, 1);
    bus_read(5'h03, 16'hA5A5, "scratch");
    bus_read(5'h1F, 16'h5A5A, "ram_1f");
    bus_read(5'h08, 16'h1111, "ram_08");
    bus_write(5'h06, 16'hFFFF, 1);
    bus_read(5'h06, 16'h0000, "reserved");
    bus_write(5'h00, 16'hFFF5, 1);
    check("ctrl_led5", {12'h000, led}, 16'h0005);
    bus_read(5'h00, 16'h0005, "ctrl_mask");
    bus_read(5'h05, 16'h0007, "wrcnt_7");

    // Debounce: a 5-cycle glitch is rejected
    btn[0] = 1'b1;
    cyc(5);
    btn[0] = 1'b0;
    cyc(12);
    bus_read(5'h01, 16'h0000, "glitch_status");
    bus_read(5'h02, 16'h0000, "glitch_event");

    // Clean press: STATUS still 0 when sampled at edge 10, 1 when sampled at edge 11
    btn[0] = 1'b1;
    cyc(9);
    bus_read(5'h01, 16'h0000, "press_edge10");
    bus_read(5'h02, 16'h0001, "press_event");
    btn[0] = 1'b0;
    cyc(15);
    bus_read(5'h01, 16'h0000, "release_status");
    btn[0] = 1'b1;
    cyc(10);
    bus_read(5'h01, 16'h0001, "press_edge11");

    // W1C
    btn[1] = 1'b1;
    cyc(14);
    bus_read(5'h02, 16'h0003, "event_3");
    bus_read(5'h01, 16'h0003, "status_3");
    bus_write(5'h02, 16'h0001, 1);
    bus_read(5'h02, 16'h0002, "w1c_bit0");
    bus_read(5'h02, 16'h0002, "read_no_clear");

    // Clear of bit1 lands on the same edge as a new btn[1] rise
    btn[1] = 1'b0;
    cyc(14);
    btn[1] = 1'b1;
    cyc(9);
    bus_write(5'h02, 16'h0002, 1);
    bus_read(5'h02, 16'h0002, "collision");
    bus_write(5'h02, 16'h0003, 1);
    bus_read(5'h02, 16'h0000, "w1c_all");
    bus_read(5'h05, 16'h000A, "wrcnt_10");

    // WRCNT wrap via backdoor preload
    force dut.wrcnt_q = 16'hFFFF;
    cyc(1);
    release dut.wrcnt_q;
    cyc(1);
    bus_read(5'h05, 16'hFFFF, "wrcnt_preload");
    bus_write(5'h03, 16'h0001, 1);
    bus_read(5'h05, 16'h0000, "wrcnt_wrap");
    bus_read(5'h03, 16'h0001, "scratch_after_wrap");

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
